// File: rtl/div_sqrt_mvp_pkg.sv
// Shared definitions for the div_sqrt_mvp mantissa path: FSM states,
// sqrt digit codes and the per-operation iteration count.
package div_sqrt_mvp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CORR = 2'd2
  } state_t;

  // Low two bits appended to the partial root: 4Q+1 when subtracting, 4Q+3 when adding.
  localparam logic [1:0] DIGIT_SUB = 2'b01;
  localparam logic [1:0] DIGIT_ADD = 2'b11;

  function automatic int unsigned iter_count(input int unsigned width, input logic op_sqrt);
    return op_sqrt ? width : width + 1;
  endfunction

endpackage

// File: rtl/iteration_div_sqrt_mvp.sv
// Combinational add/subtract step shared by the divide and square-root iterations.
module iteration_div_sqrt_mvp #(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum
);

  assign sum = op_a + (op_b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, carry_in};

endmodule

// File: rtl/mant_div_sqrt_seq_mvp.sv
// Radix-2 non-restoring mantissa divide / square-root engine; one result bit
// per cycle, followed by a single remainder-correction cycle.
module mant_div_sqrt_seq_mvp
  import div_sqrt_mvp_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Start_SI,
  input  logic             Op_SI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  output logic             Ready_SO,
  output logic             Done_SO,
  output logic [WIDTH:0]   Result_DO,
  output logic             Sticky_DO
);

  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);

  state_t           state_q, state_d;
  logic             op_sqrt_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rad_q;
  logic [RW-1:0]    rem_q;
  logic [WIDTH:0]   quo_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH:0]   result_q;
  logic             sticky_q;

  logic [RW-1:0]    iter_a, iter_b, iter_sum;
  logic             iter_sub, iter_cin;
  logic             rem_sign, first_step;
  logic [1:0]       digit;

  assign rem_sign   = rem_q[RW-1];
  assign first_step = (cnt_q == CW'(iter_count(WIDTH, 1'b0)));
  assign digit      = rem_sign ? DIGIT_ADD : DIGIT_SUB;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start_SI) state_d = ITER;
      ITER: begin
        if (Kill_SI)                 state_d = IDLE;
        else if (cnt_q <= CW'(1))    state_d = CORR;
      end
      CORR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Divide feeds 2T (T unshifted on the first step); sqrt shifts in two radicand bits.
  always_comb begin
    iter_a   = rem_q;
    iter_b   = {2'b00, div_q};
    iter_sub = 1'b0;
    iter_cin = 1'b0;
    if (state_q == CORR) begin
      iter_b = op_sqrt_q ? {1'b0, quo_q[WIDTH-1:0], 1'b1} : {2'b00, div_q};
    end else if (op_sqrt_q) begin
      iter_a   = {rem_q[RW-3:0], rad_q[WIDTH-1 -: 2]};
      iter_b   = {quo_q[WIDTH-1:0], digit};
      iter_sub = ~rem_sign;
      iter_cin = ~digit[1];
    end else begin
      iter_a   = first_step ? rem_q : {rem_q[RW-2:0], 1'b0};
      iter_sub = ~rem_sign;
      iter_cin = ~rem_sign;
    end
  end

  iteration_div_sqrt_mvp #(
    .WIDTH(RW)
  ) u_iteration (
    .op_a    (iter_a),
    .op_b    (iter_b),
    .sub     (iter_sub),
    .carry_in(iter_cin),
    .sum     (iter_sum)
  );

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      op_sqrt_q <= 1'b0;
      div_q     <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start_SI) begin
            op_sqrt_q <= Op_SI;
            div_q     <= B_DI;
            rad_q     <= A_DI;
            rem_q     <= Op_SI ? '0 : {2'b00, A_DI};
            quo_q     <= '0;
            cnt_q     <= CW'(iter_count(WIDTH, Op_SI));
          end
        end
        ITER: begin
          if (!Kill_SI) begin
            rem_q <= iter_sum;
            quo_q <= {quo_q[WIDTH-1:0], ~iter_sum[RW-1]};
            rad_q <= rad_q << 2;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CORR: begin
          if (!Kill_SI) begin
            result_q <= quo_q;
            sticky_q <= (rem_sign ? iter_sum : rem_q) != '0;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Ready_SO  = (state_q == IDLE);
  assign Done_SO   = done_q;
  assign Result_DO = result_q;
  assign Sticky_DO = sticky_q;

endmodule

// File: tb/tb_mant_div_sqrt_seq_mvp.sv
// Directed-vector and reference-model bench for the mantissa divide/sqrt engine.
module tb_mant_div_sqrt_seq_mvp;

  logic        Clk_CI;
  logic        Rst_RBI;
  logic        Start_SI;
  logic        Op_SI;
  logic        Kill_SI;
  logic [23:0] A_DI;
  logic [23:0] B_DI;
  logic        Ready_SO;
  logic        Done_SO;
  logic [24:0] Result_DO;
  logic        Sticky_DO;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;
  int t0         = 0;

  typedef struct {
    logic        op;
    logic [23:0] a;
    logic [23:0] b;
    logic [24:0] expRes;
    logic        expSticky;
    int          expLat;
  } vector_t;

  vector_t vectors[5];

  mant_div_sqrt_seq_mvp #(
    .WIDTH(24)
  ) dut (
    .Clk_CI   (Clk_CI),
    .Rst_RBI  (Rst_RBI),
    .Start_SI (Start_SI),
    .Op_SI    (Op_SI),
    .Kill_SI  (Kill_SI),
    .A_DI     (A_DI),
    .B_DI     (B_DI),
    .Ready_SO (Ready_SO),
    .Done_SO  (Done_SO),
    .Result_DO(Result_DO),
    .Sticky_DO(Sticky_DO)
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  always @(posedge Clk_CI) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Greedy bit-by-bit integer model; independent of the engine's recurrence.
  task automatic refModel(input logic op, input logic [23:0] a, input logic [23:0] b,
                          output logic [24:0] res, output logic st);
    longint unsigned n, r, t;
    n = longint'(a) << 24;
    if (!op) begin
      res = 25'(n / longint'(b));
      st  = (n % longint'(b)) != 0;
    end else begin
      r = 0;
      for (int i = 23; i >= 0; i--) begin
        t = r | (64'd1 << i);
        if (t * t <= n) r = t;
      end
      res = 25'(r);
      st  = (r * r) != n;
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic op, input logic [23:0] a, input logic [23:0] b, input logic kill);
    int waitCnt = 0;
    while (!Ready_SO && waitCnt < 60) begin
      @(negedge Clk_CI);
      waitCnt++;
    end
    if (!Ready_SO) checkOutput("readyTimeout", 0, 1);
    Start_SI = 1'b1;
    Kill_SI  = kill;
    Op_SI    = op;
    A_DI     = a;
    B_DI     = b;
    @(posedge Clk_CI);
    #1;
    Start_SI = 1'b0;
    Kill_SI  = 1'b0;
    @(negedge Clk_CI);
    t0 = cyc;
    checkOutput("readyDrop", Ready_SO, 0);
    checkOutput("donePulse", Done_SO, 0);
  endtask

  task automatic waitDone(output logic [24:0] res, output logic st, output int lat);
    bit seen = 0;
    res = '0;
    st  = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk_CI);
      if (Done_SO) begin
        seen = 1;
        res  = Result_DO;
        st   = Sticky_DO;
        lat  = cyc - t0;
      end
    end
    if (!seen) checkOutput("doneTimeout", 0, 1);
  endtask

  task automatic runVector(input string name, input logic op, input logic [23:0] a, input logic [23:0] b,
                           input logic [24:0] expRes, input logic expSticky, input int expLat, input logic kill);
    logic [24:0] res;
    logic        st;
    int          lat;
    applyStimulus(op, a, b, kill);
    waitDone(res, st, lat);
    checkOutput({name, ".result"}, res, expRes);
    checkOutput({name, ".sticky"}, st, expSticky);
    checkOutput({name, ".latency"}, lat, expLat);
  endtask

  initial begin
    logic [24:0] expRes, res;
    logic        expSt, st;
    int          lat, doneCount;
    logic        op;
    logic [23:0] a, b;

    vectors[0] = '{1'b0, 24'h800000, 24'h800000, 25'h1000000, 1'b0, 26};
    vectors[1] = '{1'b0, 24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 26};
    vectors[2] = '{1'b0, 24'hC00000, 24'h800000, 25'h1800000, 1'b0, 26};
    vectors[3] = '{1'b1, 24'h800000, 24'h800000, 25'h0B504F3, 1'b1, 25};
    vectors[4] = '{1'b1, 24'h900000, 24'h800000, 25'h0C00000, 1'b0, 25};

    Rst_RBI  = 1'b0;
    Start_SI = 1'b0;
    Op_SI    = 1'b0;
    Kill_SI  = 1'b0;
    A_DI     = '0;
    B_DI     = '0;
    repeat (3) @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);
    checkOutput("reset.ready", Ready_SO, 1);
    checkOutput("reset.done", Done_SO, 0);
    checkOutput("reset.result", Result_DO, 0);
    checkOutput("reset.sticky", Sticky_DO, 0);

    for (int i = 0; i < 5; i++)
      runVector($sformatf("vec%0d", i), vectors[i].op, vectors[i].a, vectors[i].b,
                vectors[i].expRes, vectors[i].expSticky, vectors[i].expLat, 1'b0);

    // Start while busy must be ignored.
    applyStimulus(1'b0, 24'hC00000, 24'h800000, 1'b0);
    repeat (4) @(negedge Clk_CI);
    Start_SI = 1'b1;
    Op_SI    = 1'b1;
    A_DI     = 24'h900000;
    @(posedge Clk_CI);
    #1;
    Start_SI = 1'b0;
    waitDone(res, st, lat);
    checkOutput("busy.result", res, 25'h1800000);
    checkOutput("busy.sticky", st, 0);
    checkOutput("busy.latency", lat, 26);
    @(negedge Clk_CI);
    checkOutput("busy.readyAfter", Ready_SO, 1);
    checkOutput("busy.doneOnce", Done_SO, 0);

    // Kill mid-divide: back to idle, no Done, outputs keep previous values.
    applyStimulus(1'b0, 24'h800000, 24'hC00000, 1'b0);
    repeat (9) @(negedge Clk_CI);
    Kill_SI = 1'b1;
    @(posedge Clk_CI);
    #1;
    Kill_SI = 1'b0;
    @(negedge Clk_CI);
    checkOutput("kill.ready", Ready_SO, 1);
    checkOutput("kill.done", Done_SO, 0);
    checkOutput("kill.result", Result_DO, 25'h1800000);
    checkOutput("kill.sticky", Sticky_DO, 0);
    doneCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk_CI);
      if (Done_SO) doneCount++;
    end
    checkOutput("kill.noDone", doneCount, 0);
    runVector("afterKill", 1'b0, 24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 26, 1'b0);

    // Start and Kill together in idle: the start is taken.
    runVector("startKill", 1'b1, 24'h900000, 24'h000000, 25'h0C00000, 1'b0, 25, 1'b1);

    // Reset in the middle of a square root.
    applyStimulus(1'b1, 24'h800000, 24'h800000, 1'b0);
    repeat (6) @(negedge Clk_CI);
    Rst_RBI = 1'b0;
    #1;
    checkOutput("midReset.ready", Ready_SO, 1);
    checkOutput("midReset.done", Done_SO, 0);
    checkOutput("midReset.result", Result_DO, 0);
    checkOutput("midReset.sticky", Sticky_DO, 0);
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);

    // Random legal operands, each new Start issued in the Done cycle.
    for (int i = 0; i < 800; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      b  = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      refModel(op, a, b, expRes, expSt);
      applyStimulus(op, a, b, 1'b0);
      waitDone(res, st, lat);
      checkOutput($sformatf("rand%0d.result", i), res, expRes);
      checkOutput($sformatf("rand%0d.sticky", i), st, expSt);
      checkOutput($sformatf("rand%0d.latency", i), lat, op ? 25 : 26);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
